// File: rtl/pipelined_adder_pkg.sv
// Shared parameter helpers for the pipelined add/subtract unit.
package pipelined_adder_pkg;

    // Width of one carry segment (one pipeline stage) of the adder.
    function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? width : (width / stages);
    endfunction

    // Legal geometry: at least one stage, no more stages than bits, equal segments.
    function automatic bit params_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational ripple-carry segment of SEG_W full-adder cells.
module adder_segment #(
    parameter int unsigned SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [SEG_W:0] w_c;

    assign w_c[0] = ci;

    // Carry ripples from bit 0 upwards through the fa chain.
    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        fa u_fa (
            .i_a (a[i]),
            .i_b (b[i]),
            .i_c (w_c[i]),
            .o_s (s[i]),
            .o_c (w_c[i+1])
        );
    end

    assign co       = w_c[SEG_W];
    assign c_msb_in = w_c[SEG_W-1];

endmodule

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: STAGES ripple segments, one register stage each,
// with valid/ready flow control, carry-in/out and signed-overflow flag.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SEG_W = seg_width(WIDTH, STAGES);
    localparam int unsigned LAST  = STAGES - 1;

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder: need STAGES >= 1 and WIDTH a multiple of STAGES");
    end

    // Stage registers: stage k holds the low (k+1)*SEG_W result bits, its carry-out
    // and the operands whose upper segments are still to be added.
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic              r_ovf;

    // Per-stage inputs (from the ports for stage 0, else from the previous register).
    logic [STAGES-1:0] w_in_vld;
    logic [STAGES-1:0] w_in_c;
    logic [WIDTH-1:0]  w_in_a    [STAGES];
    logic [WIDTH-1:0]  w_in_b    [STAGES];
    logic [WIDTH-1:0]  w_in_sum  [STAGES];
    logic [WIDTH-1:0]  w_nxt_sum [STAGES];
    logic [SEG_W-1:0]  w_seg_s   [STAGES];
    logic [STAGES-1:0] w_seg_co;
    logic              w_seg_cmsb [STAGES];
    logic [STAGES-1:0] w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Subtract is a + ~b + 1; this is the only place sub takes effect.
            assign w_in_vld[k] = in_valid;
            assign w_in_a[k]   = a;
            assign w_in_b[k]   = sub ? ~b : b;
            assign w_in_c[k]   = sub | cin;
            assign w_in_sum[k] = '0;
        end else begin : g_next
            assign w_in_vld[k] = r_vld[k-1];
            assign w_in_a[k]   = r_a[k-1];
            assign w_in_b[k]   = r_b[k-1];
            assign w_in_c[k]   = r_c[k-1];
            assign w_in_sum[k] = r_sum[k-1];
        end

        // A stage moves when any stage at or after it is empty, or the consumer takes a result;
        // written flat rather than as a chain so there is no combinational self-reference.
        assign w_adv[k] = out_ready | ~(&r_vld[LAST:k]);

        adder_segment #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a        (w_in_a[k][k*SEG_W +: SEG_W]),
            .b        (w_in_b[k][k*SEG_W +: SEG_W]),
            .ci       (w_in_c[k]),
            .s        (w_seg_s[k]),
            .co       (w_seg_co[k]),
            .c_msb_in (w_seg_cmsb[k])
        );

        // Bits above the finished segments are always zero, so OR-in the new segment.
        assign w_nxt_sum[k] = w_in_sum[k] | (WIDTH'(w_seg_s[k]) << (k * SEG_W));
    end

    // Stage registers: advance on w_adv, load payload only when a real op arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                r_sum[i] <= '0;
                r_a[i]   <= '0;
                r_b[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_adv[i]) begin
                    r_vld[i] <= w_in_vld[i];
                    if (w_in_vld[i]) begin
                        r_sum[i] <= w_nxt_sum[i];
                        r_a[i]   <= w_in_a[i];
                        r_b[i]   <= w_in_b[i];
                        r_c[i]   <= w_seg_co[i];
                    end
                end
            end
            if (w_adv[LAST] && w_in_vld[LAST]) begin
                r_ovf <= w_seg_co[LAST] ^ w_seg_cmsb[LAST];
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_vld[LAST];
    assign sum       = r_sum[LAST];
    assign cout      = r_c[LAST];
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (32/4 main instance, 16/1 degenerate instance).
module tb_pipelined_adder;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;

    logic        d_in_valid, d_in_ready, d_cin, d_sub, d_out_valid, d_out_ready, d_cout, d_ovf;
    logic [15:0] d_a, d_b, d_sum;

    int n_tests = 0;
    int n_fail  = 0;

    // Values sampled by step() just before the active edge.
    logic        s_acc, s_ov, s_ir, s_cout, s_ovf;
    logic [31:0] s_sum;

    res_t exp_q[$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .sum(d_sum), .cout(d_cout), .ovf(d_ovf)
    );

    // Reference: true integer arithmetic; ovf means the signed result does not fit in 32 bits.
    function automatic res_t ref_op(input logic [31:0] x, input logic [31:0] y,
                                    input logic ci, input logic sb);
        res_t            r;
        logic [31:0]     ny;
        longint unsigned u;
        longint          sr;
        ny = ~y;
        if (sb) begin
            u  = 64'(x) + 64'(ny) + 64'd1;
            sr = longint'($signed(x)) - longint'($signed(y));
        end else begin
            u  = 64'(x) + 64'(y) + 64'(ci);
            sr = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        end
        r.s = u[31:0];
        r.c = u[32];
        r.v = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
        return r;
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One clock cycle: drive at negedge, sample just after, then wait for the rising edge.
    task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic ic, input logic is, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        sub       = is;
        out_ready = ordy;
        #1;
        s_ir   = in_ready;
        s_acc  = iv & in_ready;
        s_ov   = out_valid;
        s_sum  = sum;
        s_cout = cout;
        s_ovf  = ovf;
        @(posedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] x, y;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, sum, cout, ovf} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_state: got ov=%0b sum=%h cout=%0b ovf=%0b, want all 0", out_valid, sum, cout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
        // Three ops in flight, the oldest already presented at the output.
        for (int i = 0; i < 5; i++) begin
            x = $urandom;
            y = $urandom;
            step(i < 3, x, y, 1'b0, 1'b0, 1'b0);
        end
        #1;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prefill: out_valid got %0b want 1", out_valid);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || sum !== 32'd0 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got ov=%0b sum=%h cout=%0b, want 0/0/0", out_valid, sum, cout);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            n_tests++;
            if (s_ov !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_stale: cycle %0d out_valid got %0b want 0", i, s_ov);
            end
        end
    endtask

    task automatic test_streaming();
        int got = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      step(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);
            else if (i == 1) step(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);
            else             step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            if (s_ov) begin
                n_tests++;
                if (got == 0 && (i != 4 || s_sum !== 32'd0 || s_cout !== 1'b1 || s_ovf !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL stream_wrap: got cyc=%0d sum=%h c=%0b v=%0b, want cyc=4 sum=0 c=1 v=0", i, s_sum, s_cout, s_ovf);
                end
                if (got == 1 && (i != 5 || s_sum !== 32'h8000_0000 || s_cout !== 1'b0 || s_ovf !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL stream_ovf: got cyc=%0d sum=%h c=%0b v=%0b, want cyc=5 sum=80000000 c=0 v=1", i, s_sum, s_cout, s_ovf);
                end
                got++;
            end
        end
        n_tests++;
        if (got != 2) begin
            n_fail++;
            $display("FAIL stream_count: got %0d results want 2", got);
        end
    endtask

    task automatic test_subtract();
        int got = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      step(1'b1, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1);
            else if (i == 1) step(1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1);
            else             step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            if (s_ov) begin
                n_tests++;
                if (got == 0 && (s_sum !== 32'hFFFF_FFFE || s_cout !== 1'b0 || s_ovf !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL sub_neg: got sum=%h c=%0b v=%0b, want fffffffe/0/0", s_sum, s_cout, s_ovf);
                end
                if (got == 1 && (s_sum !== 32'h7FFF_FFFF || s_cout !== 1'b1 || s_ovf !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL sub_ovf: got sum=%h c=%0b v=%0b, want 7fffffff/1/1", s_sum, s_cout, s_ovf);
                end
                got++;
            end
        end
        n_tests++;
        if (got != 2) begin
            n_fail++;
            $display("FAIL sub_count: got %0d results want 2", got);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] x, y, held;
        logic        ci, sb, have_held;
        int          nacc;
        res_t        e;
        nacc      = 0;
        have_held = 1'b0;
        held      = '0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            x  = rnd_opnd();
            y  = rnd_opnd();
            ci = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            step(1'b1, x, y, ci, sb, 1'b0);
            if (s_acc) begin
                nacc++;
                exp_q.push_back(ref_op(x, y, ci, sb));
            end
            if (s_ov) begin
                if (!have_held) begin
                    held      = s_sum;
                    have_held = 1'b1;
                end
                n_tests++;
                if (s_sum !== held || s_sum !== exp_q[0].s) begin
                    n_fail++;
                    $display("FAIL bp_hold: cycle %0d sum got %h want %h", i, s_sum, exp_q[0].s);
                end
            end
        end
        n_tests++;
        if (nacc != 4 || s_ir !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: got %0d accepted in_ready=%0b, want 4 and 0", nacc, s_ir);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            n_tests++;
            if (s_ov !== (i < 4)) begin
                n_fail++;
                $display("FAIL bp_drain_valid: cycle %0d out_valid got %0b want %0b", i, s_ov, (i < 4));
            end
            if (s_ov && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({s_sum, s_cout, s_ovf} !== {e.s, e.c, e.v}) begin
                    n_fail++;
                    $display("FAIL bp_drain_data: got %h/%0b/%0b want %h/%0b/%0b", s_sum, s_cout, s_ovf, e.s, e.c, e.v);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        logic [31:0] x, y;
        logic        ci, sb, ordy;
        res_t        e;
        exp_q.delete();
        for (int i = 0; i < 230; i++) begin
            x    = rnd_opnd();
            y    = rnd_opnd();
            ci   = 1'($urandom_range(0, 1));
            sb   = (i < 100) ? 1'b0 : 1'($urandom_range(0, 1));
            ordy = (i >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
            step((i < 200) && (i % 2 == 0), x, y, ci, sb, ordy);
            if (s_acc) exp_q.push_back(ref_op(x, y, ci, sb));
            if (s_ov && ordy) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bubble_extra: cycle %0d unexpected result %h", i, s_sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({s_sum, s_cout, s_ovf} !== {e.s, e.c, e.v}) begin
                        n_fail++;
                        $display("FAIL bubble_data: cycle %0d got %h/%0b/%0b want %h/%0b/%0b", i, s_sum, s_cout, s_ovf, e.s, e.c, e.v);
                    end
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bubble_lost: got %0d results missing want 0", exp_q.size());
        end
    endtask

    task automatic test_random_stream();
        logic [31:0] x, y;
        logic        iv, ci, sb, ordy;
        res_t        e;
        int          ndone;
        ndone = 0;
        exp_q.delete();
        for (int i = 0; i < 1540; i++) begin
            x    = rnd_opnd();
            y    = rnd_opnd();
            ci   = 1'($urandom_range(0, 1));
            sb   = 1'($urandom_range(0, 1));
            iv   = (i < 1500) && ($urandom_range(0, 3) != 0);
            ordy = (i >= 1500) || ($urandom_range(0, 3) != 0);
            step(iv, x, y, ci, sb, ordy);
            if (s_acc) exp_q.push_back(ref_op(x, y, ci, sb));
            if (s_ov && ordy) begin
                n_tests++;
                ndone++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: cycle %0d unexpected result %h", i, s_sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({s_sum, s_cout, s_ovf} !== {e.s, e.c, e.v}) begin
                        n_fail++;
                        $display("FAIL rand_data: cycle %0d got %h/%0b/%0b want %h/%0b/%0b", i, s_sum, s_cout, s_ovf, e.s, e.c, e.v);
                    end
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0 || ndone < 100) begin
            n_fail++;
            $display("FAIL rand_lost: got %0d left %0d done, want 0 left", exp_q.size(), ndone);
        end
    endtask

    // WIDTH=16, STAGES=1: one registered adder, result one cycle after acceptance.
    task automatic test_degenerate();
        logic [16:0] u;
        logic [15:0] ny, es;
        logic        ec, ev, have;
        int          sr;
        have = 1'b0;
        es   = '0;
        ec   = 1'b0;
        ev   = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            d_in_valid  = (i < 24);
            d_out_ready = 1'b1;
            d_a         = 16'($urandom);
            d_b         = 16'($urandom);
            d_cin       = 1'($urandom_range(0, 1));
            d_sub       = 1'($urandom_range(0, 1));
            #1;
            if (have) begin
                n_tests++;
                if (d_out_valid !== 1'b1 || {d_sum, d_cout, d_ovf} !== {es, ec, ev}) begin
                    n_fail++;
                    $display("FAIL deg_data: cycle %0d got v=%0b %h/%0b/%0b want v=1 %h/%0b/%0b", i, d_out_valid, d_sum, d_cout, d_ovf, es, ec, ev);
                end
            end
            n_tests++;
            if (d_in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL deg_ready: cycle %0d in_ready got %0b want 1", i, d_in_ready);
            end
            ny = ~d_b;
            if (d_sub) begin
                u  = 17'(d_a) + 17'(ny) + 17'd1;
                sr = int'($signed(d_a)) - int'($signed(d_b));
            end else begin
                u  = 17'(d_a) + 17'(d_b) + 17'(d_cin);
                sr = int'($signed(d_a)) + int'($signed(d_b)) + int'(d_cin);
            end
            es   = u[15:0];
            ec   = u[16];
            ev   = (sr > 32767) || (sr < -32768);
            have = d_in_valid;
            @(posedge clk);
        end
        d_in_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        sub         = 1'b0;
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        d_a         = '0;
        d_b         = '0;
        d_cin       = 1'b0;
        d_sub       = 1'b0;
        test_reset();
        test_streaming();
        test_subtract();
        test_backpressure();
        test_bubbles();
        test_random_stream();
        test_degenerate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
